uart_cmd_decoder: RTL
=====================

UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000, giving the maximum clk cycles allowed between bytes of one frame (10 ms at 100 MHz).
REQ-002 The block SHALL have parameter ERR_W, default 8, giving the width of the error counter.
REQ-003 The block SHALL have port clk, input, 1, the single system clock for all logic.
REQ-004 The block SHALL have port rst, input, 1, the reset; it is synchronous and active-high.
REQ-005 The block SHALL have port rx_data, input, 8, the received byte from the UART receive stage.
REQ-006 The block SHALL have port rx_valid, input, 1, a one-cycle strobe in the clk domain marking rx_data valid.
REQ-007 The block SHALL have port flap_pulse, output, 1, a one-cycle pulse per accepted FLAP command.
REQ-008 The block SHALL have port restart_pulse, output, 1, a one-cycle pulse per accepted RESTART command.
REQ-009 The block SHALL have port paused, output, 1, the game pause level.
REQ-010 The block SHALL have port busy, output, 1, high while a frame is partially received.
REQ-011 The block SHALL have port err_cnt, output, ERR_W, a saturating count of rejected frames.
REQ-012 The block SHALL have port last_cmd, output, 8, the command byte of the most recent accepted frame.

Function
REQ-013 A frame SHALL be three bytes: header 0xAA, command byte, then a check byte equal to command XOR 0xFF.
REQ-014 Command codes SHALL be 0x46 FLAP, 0x52 RESTART and 0x50 PAUSE_TOGGLE.
REQ-015 The FSM SHALL have states IDLE, GOT_HDR and GOT_CMD, and busy SHALL be high whenever the state is not IDLE.
REQ-016 In IDLE, rx_valid with 0xAA SHALL move to GOT_HDR; any other byte SHALL be dropped with no error.
REQ-017 In GOT_HDR, any byte on rx_valid, including 0xAA, SHALL be latched as the command and the FSM SHALL move to GOT_CMD.
REQ-018 In GOT_CMD, rx_valid SHALL always return the FSM to IDLE; the frame is accepted only if the check byte matches and the command is known, and otherwise err_cnt SHALL increment.
REQ-019 On an accepted frame, flap_pulse or restart_pulse SHALL be high exactly one cycle, in the cycle after the check byte's rx_valid.
REQ-020 On an accepted frame, last_cmd SHALL update in that same cycle.
REQ-021 An accepted PAUSE_TOGGLE SHALL invert paused; an accepted RESTART SHALL force paused to 0.
REQ-022 A frame timer SHALL clear on each rx_valid and count while busy; when it reaches TIMEOUT_CYCLES-1 without a byte, the FSM SHALL return to IDLE and err_cnt SHALL increment.
REQ-023 If rx_valid and timer expiry coincide, the byte SHALL win: it is processed, the timer clears, and no timeout error is counted.
REQ-024 err_cnt SHALL saturate at all-ones and never wrap.
REQ-025 At most one pulse output SHALL be high in any cycle.

Reset
REQ-026 While rst is high at a clk edge, the block SHALL set state IDLE, timer 0, flap_pulse 0, restart_pulse 0, paused 0, busy 0, err_cnt 0 and last_cmd 0x00.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame, and the discarded frame SHALL NOT count as an error.

Structure
REQ-028 Package uart_cmd_pkg SHALL hold the header constant, the three command codes, the check XOR mask and the state enum.
REQ-029 The inter-byte timeout SHALL be a sub-module frame_timer with ports clk, rst, clear, run and expired, parameterised by TIMEOUT_CYCLES.

Verification
REQ-030 Sending AA 46 B9 SHALL produce one flap_pulse one cycle after the third rx_valid, with last_cmd=0x46 and err_cnt=0.
REQ-031 Sending AA 50 AF twice SHALL take paused 0->1->0; a following AA 52 AD SHALL pulse restart_pulse and leave paused=0.
REQ-032 Sending AA 46 00 (bad check) and then AA 41 BE (unknown command) SHALL leave err_cnt=2 with no pulses.
REQ-033 Sending AA 46 and then idling TIMEOUT_CYCLES (TIMEOUT_CYCLES=50) SHALL drop busy and raise err_cnt to 1; a following AA 46 B9 SHALL be accepted.
REQ-034 Injecting 260 bad frames with ERR_W=8 SHALL hold err_cnt at 255.
REQ-035 Asserting rst after AA 46 and then sending B9 SHALL produce no pulse and leave err_cnt=0.

Source files
------------

// File: rtl/uart_cmd_decoder_pkg.sv
// ----------------------------------------------------------------------------
// uart_cmd_pkg
// Shared constants for the UART command decoder: frame header, command codes,
// check-byte XOR mask, FSM state encoding and a command-recognition helper.
// No ports (package).
// ----------------------------------------------------------------------------
package uart_cmd_pkg;

    localparam logic [7:0] HDR_BYTE    = 8'hAA;
    localparam logic [7:0] CMD_FLAP    = 8'h46;
    localparam logic [7:0] CMD_RESTART = 8'h52;
    localparam logic [7:0] CMD_PAUSE   = 8'h50;
    localparam logic [7:0] CHECK_MASK  = 8'hFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GOT_HDR = 2'd1,
        GOT_CMD = 2'd2
    } state_t;

    function automatic logic is_known_cmd(input logic [7:0] cmd);
        return (cmd == CMD_FLAP) || (cmd == CMD_RESTART) || (cmd == CMD_PAUSE);
    endfunction

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// ----------------------------------------------------------------------------
// uart_cmd_decoder_if
// Byte stream from the UART receive stage into the command decoder.
//   rx_data  : received byte
//   rx_valid : one-cycle strobe (clk domain) marking rx_data valid
// Modports: master (UART receive side drives), slave (decoder samples).
// ----------------------------------------------------------------------------
interface uart_cmd_decoder_if;

    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (output rx_data, output rx_valid);
    modport slave  (input  rx_data, input  rx_valid);

endinterface

// File: rtl/uart_cmd_decoder_frame_timer.sv
// ----------------------------------------------------------------------------
// frame_timer
// Inter-byte timeout counter for a partially received frame.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   clear   : restart the count (a byte arrived)
//   run     : count while high (a frame is in progress); held at 0 otherwise
//   expired : high in the cycle the count sits at TIMEOUT_CYCLES-1 while running
// ----------------------------------------------------------------------------
module frame_timer #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    assign expired = run && (cnt == LAST);

    // Restarting from 0 on expiry keeps the counter from wrapping while the
    // decoder is returning to IDLE.
    always_ff @(posedge clk) begin
        if (rst || clear || !run || expired) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_cmd_decoder.sv
// ----------------------------------------------------------------------------
// uart_cmd_decoder
// Decodes 3-byte command frames (0xAA, cmd, cmd^0xFF) from a UART byte stream.
//   clk           : system clock
//   rst           : synchronous active-high reset
//   rx            : byte stream (rx_data, rx_valid), slave side
//   flap_pulse    : one-cycle pulse per accepted FLAP
//   restart_pulse : one-cycle pulse per accepted RESTART
//   paused        : pause level (toggled by PAUSE_TOGGLE, cleared by RESTART)
//   busy          : a frame is partially received
//   err_cnt       : saturating count of rejected / timed-out frames
//   last_cmd      : command byte of the most recent accepted frame
// ----------------------------------------------------------------------------
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int ERR_W          = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_cmd_decoder_if.slave    rx,
    output logic                 flap_pulse,
    output logic                 restart_pulse,
    output logic                 paused,
    output logic                 busy,
    output logic [ERR_W-1:0]     err_cnt,
    output logic [7:0]           last_cmd
);

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    state_t     state, state_nxt;
    logic [7:0] cmd_q, cmd_nxt;
    logic       accept, reject, timeout;
    logic       expired;

    assign busy = (state != IDLE);

    frame_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (rx.rx_valid),
        .run     (busy),
        .expired (expired)
    );

    // A byte arriving in the expiry cycle takes priority over the timeout.
    always_comb begin
        state_nxt = state;
        cmd_nxt   = cmd_q;
        accept    = 1'b0;
        reject    = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (rx.rx_valid && (rx.rx_data == HDR_BYTE)) begin
                    state_nxt = GOT_HDR;
                end
            end
            GOT_HDR: begin
                if (rx.rx_valid) begin
                    cmd_nxt   = rx.rx_data;
                    state_nxt = GOT_CMD;
                end else if (expired) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            GOT_CMD: begin
                if (rx.rx_valid) begin
                    state_nxt = IDLE;
                    if ((rx.rx_data == (cmd_q ^ CHECK_MASK)) && is_known_cmd(cmd_q)) begin
                        accept = 1'b1;
                    end else begin
                        reject = 1'b1;
                    end
                end else if (expired) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cmd_q         <= 8'h00;
            flap_pulse    <= 1'b0;
            restart_pulse <= 1'b0;
            paused        <= 1'b0;
            err_cnt       <= '0;
            last_cmd      <= 8'h00;
        end else begin
            state         <= state_nxt;
            cmd_q         <= cmd_nxt;
            flap_pulse    <= accept && (cmd_q == CMD_FLAP);
            restart_pulse <= accept && (cmd_q == CMD_RESTART);
            if (accept) begin
                last_cmd <= cmd_q;
            end
            if (accept && (cmd_q == CMD_PAUSE)) begin
                paused <= ~paused;
            end else if (accept && (cmd_q == CMD_RESTART)) begin
                paused <= 1'b0;
            end
            if (reject || timeout) begin
                err_cnt <= sat_inc(err_cnt);
            end
        end
    end

endmodule
